// File: rtl/sync_fifo_pro_pkg.sv
// sync_fifo_pro_pkg: shared read-mode constants and address-width helper for sync_fifo_pro
package sync_fifo_pro_pkg;
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/sync_dual_port_ram.sv
// sync_dual_port_ram: single-clock dual-port RAM, one write port, one registered read port, no reset
//   clk         : rising-edge clock
//   wenc/waddr/wdata : write strobe, address, data
//   renc/raddr  : read strobe, address
//   rdata       : registered read data, holds while renc is low
module sync_dual_port_ram
    import sync_fifo_pro_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         wenc,
    input  logic [addr_width(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         renc,
    input  logic [addr_width(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]             rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (wenc) mem[waddr] <= wdata;
        if (renc) rdata_q <= mem[raddr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: single-clock FIFO with occupancy count, almost flags, error pulses and optional FWFT read
//   clk, rstn            : clock, asynchronous active-low reset
//   winc, wdata          : write request and data
//   rinc, rdata          : read request (pop) and read data
//   wfull, rempty        : full / empty (FWFT: no valid word on rdata)
//   almost_full/empty    : fifo_cnt >= AFULL_TH / fifo_cnt <= AEMPTY_TH
//   fifo_cnt             : words held, 0..DEPTH
//   wr_ovf, rd_udf       : registered one-cycle pulses for rejected write / read requests
module sync_fifo_pro
    import sync_fifo_pro_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       winc,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rinc,
    output logic [WIDTH-1:0]           rdata,
    output logic                       wfull,
    output logic                       rempty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [addr_width(DEPTH):0] fifo_cnt,
    output logic                       wr_ovf,
    output logic                       rd_udf
);
    localparam int AW = addr_width(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_TH);
    localparam logic IS_FWFT = (FWFT == FIFO_MODE_FWFT);
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_pro: DEPTH must be a power of 2 and at least 4");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_pro: AFULL_TH out of range");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_pro: AEMPTY_TH out of range");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_pro: FWFT must be 0 or 1");
    end
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d, ram_cnt;
    logic             valid_q, valid_d, seen_q, seen_d;
    logic             wr_ovf_q, wr_ovf_d, rd_udf_q, rd_udf_d;
    logic             wen, ren, fetch, ram_ren;
    logic [WIDTH-1:0] ram_rdata;
    // In FWFT mode the RAM's own output register is the head-word register;
    // valid_q marks it occupied and ram_cnt is what still sits in the array.
    always_comb begin
        wfull    = cnt_q == FULL_C;
        rempty   = IS_FWFT ? !valid_q : (cnt_q == '0);
        wen      = winc & !wfull;
        ren      = rinc & !rempty;
        ram_cnt  = cnt_q - CW'(valid_q);
        fetch    = IS_FWFT && (ram_cnt != '0) && (!valid_q || ren);
        ram_ren  = IS_FWFT ? fetch : ren;
        wr_ptr_d = wen ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = ram_ren ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = (wen && !ren) ? cnt_q + CW'(1) : (ren && !wen) ? cnt_q - CW'(1) : cnt_q;
        valid_d  = fetch | (valid_q & !ren);
        seen_d   = seen_q | ram_ren;
        wr_ovf_d = winc & wfull;
        rd_udf_d = rinc & rempty;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            seen_q   <= 1'b0;
            wr_ovf_q <= 1'b0;
            rd_udf_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            wr_ovf_q <= wr_ovf_d;
            rd_udf_q <= rd_udf_d;
        end
    end
    sync_dual_port_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
        .clk  (clk),
        .wenc (wen),
        .waddr(wr_ptr_q),
        .wdata(wdata),
        .renc (ram_ren),
        .raddr(rd_ptr_q),
        .rdata(ram_rdata)
    );
    // The RAM output register has no reset, so rdata reads as zero until the first read since reset.
    assign rdata        = seen_q ? ram_rdata : '0;
    assign almost_full  = cnt_q >= AF_C;
    assign almost_empty = cnt_q <= AE_C;
    assign fifo_cnt     = cnt_q;
    assign wr_ovf       = wr_ovf_q;
    assign rd_udf       = rd_udf_q;
endmodule
